hazard3_sd_dma_ahb: RTL and testbench
=====================================

Name: hazard3_sd_dma_ahb

Overview:
Wishbone-slave-to-AHB5-master bridge for the SD controller's DMA port. The sdc_controller master interface (m_wb_*) connects here. Each Wishbone beat becomes one AHB SINGLE transfer on the SD block's AHB5 master port, so SD block data lands in system RAM. The APB side of the SD block is the register path; this block is the data path.

Parameters:
W_ADDR, 32, AHB/Wishbone address width
W_DATA, 32, data width; only 32 is supported
ADDR_OFFSET, 32'h0, added modulo 2^W_ADDR to every Wishbone address before it is driven on haddr

Ports:
clk  input  1  system clock; one clock domain
rst_n  input  1  asynchronous active-low reset
wb_adr_i  input  W_ADDR  Wishbone byte address; bits [1:0] are ignored
wb_sel_i  input  4  byte lane selects
wb_we_i  input  1  1 = write to memory
wb_dat_i  input  W_DATA  write data
wb_dat_o  output  W_DATA  read data
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_cti_i  input  3  cycle type; ignored, every beat is treated as classic
wb_bte_i  input  2  burst type; ignored
wb_ack_o  output  1  one-cycle completion pulse
wb_err_o  output  1  one-cycle error completion pulse
haddr  output  W_ADDR  AHB address
hwrite  output  1  AHB write
htrans  output  2  IDLE=00, NONSEQ=10
hsize  output  3  0 = byte, 1 = half-word, 2 = word
hburst  output  3  constant 3'b000 (SINGLE)
hprot  output  4  constant 4'b0011
hmastlock  output  1  constant 0
hexcl  output  1  constant 0
hready  input  1  AHB ready
hresp  input  1  AHB error response
hwdata  output  W_DATA  AHB write data
hrdata  input  W_DATA  AHB read data

Behaviour:
- Reset values: htrans=00, haddr=0, hwrite=0, hsize=2, hwdata=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0; state=IDLE. Reset is asynchronous, so mid-transfer reset returns everything to these values immediately.
- State machine states: IDLE, ADDR, DATA, RESP.
- IDLE, entry condition: when wb_cyc_i & wb_stb_i are both high, decode wb_sel_i.
- IDLE, lane decode:
  - f -> hsize=2, addr[1:0]=00.
  - 3 -> hsize=1, 00; c -> hsize=1, 10.
  - 1/2/4/8 -> hsize=0, 00/01/10/11.
- IDLE, lane decode outcome:
  - Valid pattern: register haddr = {wb_adr_i[W_ADDR-1:2], lanebits} + ADDR_OFFSET, plus hwrite and hsize. Set htrans=NONSEQ and go to ADDR.
  - Any other pattern (including 0): pulse wb_err_o next cycle via RESP. No AHB transfer is issued.
- ADDR: htrans stays NONSEQ and haddr is stable until hready=1. On that edge:
  - htrans <= IDLE.
  - hwdata <= wb_dat_i (full word, all lanes; slaves use haddr/hsize).
  - Go to DATA.
- DATA: wait for hready=1.
  - Read: capture hrdata into wb_dat_o.
  - hresp=1 with hready=1: error completion.
  - hresp=1 with hready=0 (first error cycle): stay in DATA and keep htrans=IDLE.
  - Then go to RESP.
- RESP: drive wb_ack_o or wb_err_o high for exactly one cycle, then go to IDLE.
  - The ack is registered, so the master may present its next beat in the same cycle the bridge returns to IDLE.
  - No extra idle cycle is required.
- Latency, zero-wait-state: stb sampled in cycle 0, NONSEQ in cycle 1, data phase in cycle 2, ack in cycle 3. Each AHB wait state adds one cycle.
- Abort: if wb_cyc_i drops while in ADDR or DATA, the AHB transfer still completes (AHB cannot abort). RESP then suppresses both ack and err, and the state returns to IDLE.
- wb_dat_o holds its last captured value; it is not cleared on writes.
- At most one outstanding transfer; no buffering and no write posting.
- haddr wraps modulo 2^W_ADDR when ADDR_OFFSET is added.

Test Plan:
- Write, hready=1: adr=0x100, sel=f, dat=0xDEADBEEF, ADDR_OFFSET=0x20000000 -> NONSEQ haddr=0x20000100, hsize=2, hwrite=1 in cycle 1; hwdata=0xDEADBEEF in cycle 2; wb_ack_o in cycle 3 only.
- Read with 2 wait states: adr=0x40, hrdata=0x12345678 valid when hready rises -> wb_dat_o=0x12345678, wb_ack_o at cycle 5, single pulse.
- Byte/half lanes: sel=4 -> haddr[1:0]=10, hsize=0; sel=c -> 10, hsize=1; sel=5 -> wb_err_o pulse, htrans stays IDLE throughout.
- AHB error: hresp=1 for two cycles (hready 0 then 1) -> htrans IDLE during the response, wb_err_o=1 one cycle, wb_ack_o=0.
- Back-to-back beats: 4 writes at 0x0, 0x4, 0x8, 0xC with stb held -> 4 NONSEQ transfers in order, 4 ack pulses, no duplicate transfer after any ack.
- Disruption: drop wb_cyc_i in DATA -> transfer finishes with no ack. Assert rst_n=0 mid-ADDR -> htrans=00 and wb_ack_o=0 immediately (asynchronous reset).

Source files
------------

// File: rtl/hazard3_sd_dma_ahb_if.sv
// Bus bundle between the SD controller DMA Wishbone master and the AHB5 fabric.
// The bridge uses the "master" view: it accepts Wishbone beats and drives AHB
// as a master. The surrounding system uses the "slave" view.
//
// Handshake semantics: a Wishbone beat is offered while wb_cyc_i & wb_stb_i are
// high and is retired by exactly one wb_ack_o or wb_err_o pulse. An AHB address
// or data phase advances only on a cycle where hready is high. htrans=NONSEQ is
// the AHB "valid" and is held, with haddr stable, until hready accepts it.
interface hazard3_sd_dma_ahb_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  // Wishbone slave side (toward sdc_controller m_wb_*)
  logic [W_ADDR-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic              wb_we_i;
  logic [W_DATA-1:0] wb_dat_i;
  logic [W_DATA-1:0] wb_dat_o;
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic [2:0]        wb_cti_i;
  logic [1:0]        wb_bte_i;
  logic              wb_ack_o;
  logic              wb_err_o;

  // AHB5 master side (toward system RAM)
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic              hexcl;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  // Current bridge state: 0 IDLE, 1 ADDR, 2 DATA, 3 RESP
  logic [1:0]        dbg_state;

  modport master (
    input  wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl,
           hwdata,
    input  hready, hresp, hrdata,
    output dbg_state
  );

  modport slave (
    output wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl,
           hwdata,
    output hready, hresp, hrdata,
    input  dbg_state
  );
endinterface

// File: rtl/hazard3_sd_dma_ahb.sv
// Wishbone-slave to AHB5-master bridge for the SD controller DMA data path.
// Every Wishbone beat becomes one AHB SINGLE transfer; one transfer in flight.
module hazard3_sd_dma_ahb #(
  parameter int                W_ADDR      = 32,
  parameter int                W_DATA      = 32,
  parameter logic [W_ADDR-1:0] ADDR_OFFSET = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard3_sd_dma_ahb_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t            state_q,  state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [W_ADDR-1:0] haddr_q,  haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q,  hsize_d;
  logic [W_DATA-1:0] hwdata_q, hwdata_d;
  logic              ack_q,    ack_d;
  logic              err_q,    err_d;
  logic [W_DATA-1:0] dat_o_q,  dat_o_d;
  // Set once the master abandons the cycle; the AHB transfer still runs out
  logic              abort_q,  abort_d;

  logic              lane_ok;
  logic [1:0]        lane_lo;
  logic [2:0]        lane_size;
  logic              abort_now;

  // Cycle type, burst type and the byte offset bits carry no information here
  logic unused_inputs;
  assign unused_inputs = ^{bus.wb_cti_i, bus.wb_bte_i, bus.wb_adr_i[1:0]};

  // Translate Wishbone byte lanes into AHB size and low address bits
  always_comb begin
    lane_ok   = 1'b1;
    lane_lo   = 2'b00;
    lane_size = 3'd2;
    case (bus.wb_sel_i)
      4'hf: begin lane_size = 3'd2; lane_lo = 2'b00; end
      4'h3: begin lane_size = 3'd1; lane_lo = 2'b00; end
      4'hc: begin lane_size = 3'd1; lane_lo = 2'b10; end
      4'h1: begin lane_size = 3'd0; lane_lo = 2'b00; end
      4'h2: begin lane_size = 3'd0; lane_lo = 2'b01; end
      4'h4: begin lane_size = 3'd0; lane_lo = 2'b10; end
      4'h8: begin lane_size = 3'd0; lane_lo = 2'b11; end
      default: lane_ok = 1'b0;
    endcase
  end

  assign abort_now = abort_q | ~bus.wb_cyc_i;

  // Next-state and registered-output logic for the four-state transfer FSM
  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    dat_o_d  = dat_o_q;
    abort_d  = abort_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          if (lane_ok) begin
            haddr_d  = {bus.wb_adr_i[W_ADDR-1:2], lane_lo} + ADDR_OFFSET;
            hwrite_d = bus.wb_we_i;
            hsize_d  = lane_size;
            htrans_d = HTRANS_NONSEQ;
            state_d  = S_ADDR;
          end else begin
            // Unsupported lane pattern: refuse without touching AHB
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_ADDR: begin
        abort_d = abort_now;
        if (bus.hready) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = bus.wb_dat_i;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        abort_d = abort_now;
        // hresp high with hready low is the first error cycle: keep waiting
        if (bus.hready) begin
          if (!hwrite_q && !bus.hresp) begin
            dat_o_d = bus.hrdata;
          end
          if (!abort_now) begin
            ack_d = ~bus.hresp;
            err_d = bus.hresp;
          end
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        // ack/err pulse is visible this cycle; next beat may arrive at once
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd2;
      hwdata_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_o_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_o_q  <= dat_o_d;
      abort_q  <= abort_d;
    end
  end

  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.htrans    = htrans_q;
  assign bus.hsize     = hsize_q;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.hmastlock = 1'b0;
  assign bus.hexcl     = 1'b0;
  assign bus.hwdata    = hwdata_q;
  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.wb_dat_o  = dat_o_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_hazard3_sd_dma_ahb.sv
// Bench for the SD DMA Wishbone-to-AHB bridge: AHB slave model, scoreboard of
// expected AHB transfers, and one task per scenario.
`timescale 1ns/1ps
module tb_hazard3_sd_dma_ahb;

  localparam logic [31:0] OFFS = 32'h2000_0000;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard3_sd_dma_ahb_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  hazard3_sd_dma_ahb #(.W_ADDR(32), .W_DATA(32), .ADDR_OFFSET(OFFS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cycle_cnt = 0;

  initial forever begin
    @(posedge clk);
    cycle_cnt++;
  end

  // ---------------- AHB slave model ----------------
  int          ws_cfg = 0;     // data-phase wait states
  bit          err_cfg = 0;    // two-cycle ERROR response
  int          aleft = 0;      // address-phase wait states remaining
  logic [31:0] rdata_cfg = '0;
  bit          s_dph = 0;
  int          dleft = 0;

  initial begin
    logic n_ready, n_resp;
    logic [31:0] n_rdata;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = JUNK;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_dph = 0;
      end else begin
        if (s_dph && bus.hready) s_dph = 0;
        if (bus.htrans == 2'b10 && !bus.hready && aleft > 0) aleft--;
        if (bus.htrans == 2'b10 && bus.hready) begin
          s_dph = 1;
          dleft = ws_cfg;
        end
      end
      n_ready = (aleft == 0);
      n_resp  = 1'b0;
      n_rdata = JUNK;
      if (s_dph) begin
        if (dleft > 0) begin
          n_ready = 1'b0;
          n_resp  = err_cfg && (dleft == 1);
          dleft--;
        end else begin
          n_ready = 1'b1;
          n_resp  = err_cfg;
          n_rdata = rdata_cfg;
        end
      end
      @(posedge clk);
      #1;
      bus.hready = n_ready;
      bus.hresp  = n_resp;
      bus.hrdata = n_rdata;
    end
  end

  // ---------------- scoreboard ----------------
  // {haddr[31:0], hwrite, hsize[2:0], hwdata[31:0]}
  logic [67:0] exp_q[$];
  int          ack_cnt = 0, err_cnt = 0, ns_cnt = 0, idle_viol = 0;
  int          ns_cycle = 0, wd_cycle = 0;
  bit          mon_dph = 0, mon_wr = 0;
  logic [31:0] mon_wd = '0;

  initial forever begin
    logic [67:0] e;
    @(negedge clk);
    if (!rst_n) begin
      mon_dph = 0;
    end else begin
      if (bus.wb_ack_o) ack_cnt++;
      if (bus.wb_err_o) err_cnt++;
      if (mon_dph) begin
        if (bus.htrans !== 2'b00) idle_viol++;
        if (bus.hready) begin
          mon_dph  = 0;
          wd_cycle = cycle_cnt;
          if (mon_wr) begin
            chk_cnt++;
            if (bus.hwdata !== mon_wd)
              $display("FAIL hwdata: got %h expected %h", bus.hwdata, mon_wd);
            else pass_cnt++;
          end
        end
      end
      if (bus.htrans === 2'b10 && bus.hready) begin
        ns_cycle = cycle_cnt;
        ns_cnt++;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL xfer_unexpected: haddr %h with empty expected queue", bus.haddr);
        end else begin
          e = exp_q.pop_front();
          if ({bus.haddr, bus.hwrite, bus.hsize} !== e[67:32])
            $display("FAIL xfer_addr: got haddr %h hwrite %b hsize %0d expected %h %b %0d",
                     bus.haddr, bus.hwrite, bus.hsize, e[67:36], e[35], e[34:32]);
          else pass_cnt++;
          mon_wr  = e[35];
          mon_wd  = e[31:0];
          mon_dph = 1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  int          beat_t0 = 0, beat_rel = 0;
  bit          got_ack = 0, got_err = 0;
  logic [31:0] exp_dat = '0;

  function automatic void lane_model(input logic [3:0] sel, output bit ok,
                                     output logic [1:0] lo, output logic [2:0] sz);
    ok = 1; lo = 2'b00; sz = 3'd2;
    case (sel)
      4'hf: begin sz = 3'd2; lo = 2'b00; end
      4'h3: begin sz = 3'd1; lo = 2'b00; end
      4'hc: begin sz = 3'd1; lo = 2'b10; end
      4'h1: begin sz = 3'd0; lo = 2'b00; end
      4'h2: begin sz = 3'd0; lo = 2'b01; end
      4'h4: begin sz = 3'd0; lo = 2'b10; end
      4'h8: begin sz = 3'd0; lo = 2'b11; end
      default: ok = 0;
    endcase
  endfunction

  task automatic drive_beat(input logic [31:0] adr, input logic [3:0] sel,
                            input logic we, input logic [31:0] dat);
    bit ok;
    logic [1:0] lo;
    logic [2:0] sz;
    logic [31:0] a;
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_dat_i = dat;
    bus.wb_cti_i = 3'($urandom_range(7));
    bus.wb_bte_i = 2'($urandom_range(3));
    beat_t0 = cycle_cnt;
    lane_model(sel, ok, lo, sz);
    a = {adr[31:2], lo} + OFFS;
    if (ok) exp_q.push_back({a, we, sz, dat});
  endtask

  task automatic do_beat(input logic [31:0] adr, input logic [3:0] sel,
                         input logic we, input logic [31:0] dat);
    bit done;
    drive_beat(adr, sel, we, dat);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) done = 1;
    end
    beat_rel = cycle_cnt - beat_t0;
    got_ack  = bus.wb_ack_o;
    got_err  = bus.wb_err_o;
    chk_cnt++;
    if (!done) $display("FAIL beat_timeout: no completion for adr %h", adr);
    else pass_cnt++;
  endtask

  task automatic wb_release();
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_adr_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 0; bus.wb_dat_i = '0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.htrans !== 2'b00) $display("FAIL rst_htrans: got %b expected 00", bus.htrans); else pass_cnt++;
    chk_cnt++; if (bus.haddr !== 32'h0) $display("FAIL rst_haddr: got %h expected 0", bus.haddr); else pass_cnt++;
    chk_cnt++; if (bus.hwrite !== 1'b0) $display("FAIL rst_hwrite: got %b expected 0", bus.hwrite); else pass_cnt++;
    chk_cnt++; if (bus.hsize !== 3'd2) $display("FAIL rst_hsize: got %0d expected 2", bus.hsize); else pass_cnt++;
    chk_cnt++; if (bus.hwdata !== 32'h0) $display("FAIL rst_hwdata: got %h expected 0", bus.hwdata); else pass_cnt++;
    chk_cnt++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) $display("FAIL rst_ack_err: got %b expected 00", {bus.wb_ack_o, bus.wb_err_o}); else pass_cnt++;
    chk_cnt++; if (bus.wb_dat_o !== 32'h0) $display("FAIL rst_dat_o: got %h expected 0", bus.wb_dat_o); else pass_cnt++;
    chk_cnt++; if (bus.dbg_state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", bus.dbg_state); else pass_cnt++;
    chk_cnt++;
    if ({bus.hburst, bus.hprot, bus.hmastlock, bus.hexcl} !== {3'b000, 4'b0011, 1'b0, 1'b0})
      $display("FAIL const_ctrl: got hburst %b hprot %b lock %b excl %b expected 000 0011 0 0",
               bus.hburst, bus.hprot, bus.hmastlock, bus.hexcl);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int a0 = ack_cnt;
    do_beat(32'h100, 4'hf, 1'b1, 32'hDEADBEEF);
    chk_cnt++; if (ns_cycle - beat_t0 !== 1) $display("FAIL wr_nonseq_cycle: got %0d expected 1", ns_cycle - beat_t0); else pass_cnt++;
    chk_cnt++; if (wd_cycle - beat_t0 !== 2) $display("FAIL wr_data_cycle: got %0d expected 2", wd_cycle - beat_t0); else pass_cnt++;
    chk_cnt++; if (beat_rel !== 3 || !got_ack || got_err) $display("FAIL wr_ack: cycle %0d ack %b err %b expected 3 1 0", beat_rel, got_ack, got_err); else pass_cnt++;
    wb_release();
    repeat (3) @(negedge clk);
    chk_cnt++; if (ack_cnt - a0 !== 1) $display("FAIL wr_ack_pulses: got %0d expected 1", ack_cnt - a0); else pass_cnt++;
  endtask

  task automatic test_read_wait();
    int a0 = ack_cnt;
    ws_cfg = 2; rdata_cfg = 32'h12345678; exp_dat = 32'h12345678;
    do_beat(32'h40, 4'hf, 1'b0, 32'h0);
    chk_cnt++; if (beat_rel !== 5 || !got_ack) $display("FAIL rd_ack_cycle: got %0d ack %b expected 5 1", beat_rel, got_ack); else pass_cnt++;
    chk_cnt++; if (bus.wb_dat_o !== exp_dat) $display("FAIL rd_data: got %h expected %h", bus.wb_dat_o, exp_dat); else pass_cnt++;
    wb_release();
    repeat (3) @(negedge clk);
    chk_cnt++; if (ack_cnt - a0 !== 1) $display("FAIL rd_ack_pulses: got %0d expected 1", ack_cnt - a0); else pass_cnt++;
    ws_cfg = 0;
  endtask

  task automatic test_lanes();
    logic [3:0] sels[8];
    bit ok; logic [1:0] lo; logic [2:0] sz;
    logic we;
    sels = '{4'h4, 4'hc, 4'h5, 4'h1, 4'h2, 4'h8, 4'h3, 4'h0};
    for (int i = 0; i < 8; i++) begin
      we = 1'($urandom_range(1));
      rdata_cfg = $urandom();
      lane_model(sels[i], ok, lo, sz);
      if (ok && !we) exp_dat = rdata_cfg;
      do_beat(32'h0000_0200 + 32'(i * 4), sels[i], we, $urandom());
      chk_cnt++;
      if (got_ack !== ok || got_err !== !ok)
        $display("FAIL lane_completion sel %h: ack %b err %b expected %b %b", sels[i], got_ack, got_err, ok, !ok);
      else pass_cnt++;
      if (!ok) begin
        chk_cnt++; if (beat_rel !== 1) $display("FAIL lane_err_cycle sel %h: got %0d expected 1", sels[i], beat_rel); else pass_cnt++;
      end
      chk_cnt++; if (bus.wb_dat_o !== exp_dat) $display("FAIL lane_dat_o sel %h: got %h expected %h", sels[i], bus.wb_dat_o, exp_dat); else pass_cnt++;
      wb_release();
    end
    repeat (2) @(negedge clk);
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL lane_drain: %0d transfers outstanding expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_ahb_error();
    int a0 = ack_cnt, e0 = err_cnt, v0 = idle_viol;
    ws_cfg = 1; err_cfg = 1;
    do_beat(32'h300, 4'hf, 1'b1, 32'hCAFEF00D);
    chk_cnt++; if (beat_rel !== 4 || !got_err || got_ack) $display("FAIL err_completion: cycle %0d err %b ack %b expected 4 1 0", beat_rel, got_err, got_ack); else pass_cnt++;
    wb_release();
    repeat (3) @(negedge clk);
    chk_cnt++; if (err_cnt - e0 !== 1 || ack_cnt - a0 !== 0) $display("FAIL err_pulses: err %0d ack %0d expected 1 0", err_cnt - e0, ack_cnt - a0); else pass_cnt++;
    chk_cnt++; if (idle_viol - v0 !== 0) $display("FAIL err_htrans_idle: %0d non-IDLE data cycles expected 0", idle_viol - v0); else pass_cnt++;
    ws_cfg = 0; err_cfg = 0;
  endtask

  task automatic test_back_to_back();
    int a0 = ack_cnt, n0 = ns_cnt;
    for (int i = 0; i < 4; i++) begin
      do_beat(32'(i * 4), 4'hf, 1'b1, 32'hA5A5_0000 + 32'(i));
      chk_cnt++; if (beat_rel !== 3 || !got_ack) $display("FAIL b2b_beat%0d: cycle %0d ack %b expected 3 1", i, beat_rel, got_ack); else pass_cnt++;
    end
    wb_release();
    repeat (4) @(negedge clk);
    chk_cnt++; if (ns_cnt - n0 !== 4) $display("FAIL b2b_transfers: got %0d expected 4", ns_cnt - n0); else pass_cnt++;
    chk_cnt++; if (ack_cnt - a0 !== 4) $display("FAIL b2b_acks: got %0d expected 4", ack_cnt - a0); else pass_cnt++;
  endtask

  task automatic test_addr_wait_wrap();
    aleft = 2;
    do_beat(32'hF000_0010, 4'h8, 1'b1, 32'h0000_00EE);
    chk_cnt++; if (beat_rel !== 5 || !got_ack) $display("FAIL addr_wait: cycle %0d ack %b expected 5 1", beat_rel, got_ack); else pass_cnt++;
    wb_release();
    aleft = 0;
  endtask

  task automatic test_abort();
    int a0 = ack_cnt, e0 = err_cnt;
    bit seen;
    ws_cfg = 3;
    drive_beat(32'h500, 4'hf, 1'b1, 32'h1111_2222);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.htrans === 2'b10 && bus.hready) seen = 1;
    end
    chk_cnt++; if (!seen) $display("FAIL abort_nonseq_timeout: no address phase"); else pass_cnt++;
    wb_release();
    repeat (8) @(negedge clk);
    chk_cnt++; if (ack_cnt - a0 !== 0 || err_cnt - e0 !== 0) $display("FAIL abort_completion: ack %0d err %0d expected 0 0", ack_cnt - a0, err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0 || bus.dbg_state !== 2'd0) $display("FAIL abort_drain: queue %0d state %0d expected 0 0", exp_q.size(), bus.dbg_state); else pass_cnt++;
    ws_cfg = 0;
    do_beat(32'h504, 4'hf, 1'b1, 32'h3333_4444);
    chk_cnt++; if (!got_ack) $display("FAIL abort_recover: ack %b expected 1", got_ack); else pass_cnt++;
    wb_release();
  endtask

  task automatic test_reset_mid();
    bit seen;
    aleft = 1000;
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_adr_i = 32'h600; bus.wb_sel_i = 4'hf;
    bus.wb_we_i = 1; bus.wb_dat_i = 32'h5555_AAAA;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.htrans === 2'b10) seen = 1;
    end
    chk_cnt++; if (!seen) $display("FAIL rstmid_nonseq_timeout: no NONSEQ seen"); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.htrans !== 2'b00 || bus.wb_ack_o !== 1'b0) $display("FAIL rstmid_async: htrans %b ack %b expected 00 0", bus.htrans, bus.wb_ack_o); else pass_cnt++;
    chk_cnt++; if (bus.haddr !== 32'h0 || bus.dbg_state !== 2'd0) $display("FAIL rstmid_state: haddr %h state %0d expected 0 0", bus.haddr, bus.dbg_state); else pass_cnt++;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
    aleft = 0;
    exp_dat = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rdata_cfg = 32'h0BADF00D; exp_dat = 32'h0BADF00D;
    do_beat(32'h604, 4'hf, 1'b0, 32'h0);
    chk_cnt++; if (!got_ack || bus.wb_dat_o !== exp_dat) $display("FAIL rstmid_recover: ack %b dat %h expected 1 %h", got_ack, bus.wb_dat_o, exp_dat); else pass_cnt++;
    wb_release();
    repeat (2) @(negedge clk);
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL final_drain: %0d transfers outstanding expected 0", exp_q.size()); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_lanes();
    test_ahb_error();
    test_back_to_back();
    test_addr_wait_wrap();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
